// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// button_conditioner: synchronise, debounce and classify pushbutton/switch
// inputs into press, release, long-press and auto-repeat pulses.  Rev 1.0
// ============================================================================
module button_conditioner #(
    parameter int WIDTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 200,
    parameter int LONG_CNT_MAX   = 2000,
    parameter int REPEAT_CNT_MAX = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] i_repeat_en,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_press,
    output logic [WIDTH-1:0] o_release,
    output logic [WIDTH-1:0] o_long_press,
    output logic [WIDTH-1:0] o_repeat
);

    localparam int DW = $clog2(PULSE_CNT_MAX + 1);
    localparam int HW = $clog2(LONG_CNT_MAX + 1);
    localparam int RW = $clog2(REPEAT_CNT_MAX + 1);

    localparam logic [DW-1:0] C_DLAST = DW'(PULSE_CNT_MAX - 1);
    localparam logic [HW-1:0] C_HLAST = HW'(LONG_CNT_MAX - 1);
    localparam logic [RW-1:0] C_RLAST = RW'(REPEAT_CNT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_samp;
    logic             w_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_samp = r_sync[SYNC_STAGES-1];

    generate
        if (SAMPLE_CNT_MAX > 1) begin : g_tick_div
            localparam int TW = $clog2(SAMPLE_CNT_MAX);
            localparam logic [TW-1:0] C_TLAST = TW'(SAMPLE_CNT_MAX - 1);
            logic [TW-1:0] r_tcnt;

            assign w_tick = (r_tcnt == C_TLAST);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_tcnt <= '0;
                end else if (w_tick) begin
                    r_tcnt <= '0;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end
        end else begin : g_tick_always
            assign w_tick = 1'b1;
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic [DW-1:0] r_dcnt;
            logic          r_lvl;
            logic          w_flip;
            logic          w_rise;
            logic          w_fall;

            state_t        r_state;
            state_t        w_state_nxt;
            logic [HW-1:0] r_hcnt;
            logic [HW-1:0] w_hcnt_nxt;
            logic [RW-1:0] r_rcnt;
            logic [RW-1:0] w_rcnt_nxt;
            logic          r_press, r_rel, r_long, r_rep;
            logic          w_press_nxt, w_rel_nxt, w_long_nxt, w_rep_nxt;

            // The flip is decided combinationally so the event FSM can pulse
            // press/release in the same cycle the registered level changes.
            assign w_flip = w_tick && (w_samp[i] != r_lvl) && (r_dcnt == C_DLAST);
            assign w_rise = w_flip && !r_lvl;
            assign w_fall = w_flip && r_lvl;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_dcnt <= '0;
                    r_lvl  <= 1'b0;
                end else if (w_tick) begin
                    if (w_samp[i] != r_lvl) begin
                        if (r_dcnt == C_DLAST) begin
                            r_lvl  <= ~r_lvl;
                            r_dcnt <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end else begin
                        r_dcnt <= '0;
                    end
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_hcnt_nxt  = r_hcnt;
                w_rcnt_nxt  = r_rcnt;
                w_press_nxt = 1'b0;
                w_rel_nxt   = 1'b0;
                w_long_nxt  = 1'b0;
                w_rep_nxt   = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            w_press_nxt = 1'b1;
                            w_hcnt_nxt  = '0;
                            w_state_nxt = ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (w_fall) begin
                            w_rel_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_tick) begin
                            w_hcnt_nxt = r_hcnt + 1'b1;
                            if (r_hcnt == C_HLAST) begin
                                w_long_nxt  = 1'b1;
                                w_rcnt_nxt  = '0;
                                w_state_nxt = ST_LONG;
                            end
                        end
                    end
                    ST_LONG: begin
                        if (w_fall) begin
                            w_rel_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_tick) begin
                            // Disabling repeat discards partial progress.
                            if (!i_repeat_en[i]) begin
                                w_rcnt_nxt = '0;
                            end else if (r_rcnt == C_RLAST) begin
                                w_rep_nxt  = 1'b1;
                                w_rcnt_nxt = '0;
                            end else begin
                                w_rcnt_nxt = r_rcnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state <= ST_IDLE;
                    r_hcnt  <= '0;
                    r_rcnt  <= '0;
                    r_press <= 1'b0;
                    r_rel   <= 1'b0;
                    r_long  <= 1'b0;
                    r_rep   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_hcnt  <= w_hcnt_nxt;
                    r_rcnt  <= w_rcnt_nxt;
                    r_press <= w_press_nxt;
                    r_rel   <= w_rel_nxt;
                    r_long  <= w_long_nxt;
                    r_rep   <= w_rep_nxt;
                end
            end

            assign o_level[i]      = r_lvl;
            assign o_press[i]      = r_press;
            assign o_release[i]    = r_rel;
            assign o_long_press[i] = r_long;
            assign o_repeat[i]     = r_rep;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// tb_button_conditioner: directed and random stimulus against a tick-level
// behavioural model of the button conditioner.  Rev 1.0
// ============================================================================
module tb_button_conditioner;

    localparam int W      = 2;
    localparam int SYNC   = 2;
    localparam int SMAX   = 4;
    localparam int PULSE  = 3;
    localparam int LONG   = 5;
    localparam int REPEAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] tb_in;
    logic [W-1:0] tb_en;
    logic [W-1:0] o_level, o_press, o_release, o_long_press, o_repeat;

    button_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .SAMPLE_CNT_MAX(SMAX),
        .PULSE_CNT_MAX(PULSE), .LONG_CNT_MAX(LONG), .REPEAT_CNT_MAX(REPEAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_in(tb_in), .i_repeat_en(tb_en),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_long_press(o_long_press), .o_repeat(o_repeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw-input history, tick phase, run length of
    // disagreeing samples, and ticks elapsed since the press.
    logic [W-1:0] m_hist [SYNC];
    int           m_phase;
    int           m_run  [W];
    bit           m_lvl  [W];
    bit           m_pressed [W];
    int           m_held [W];
    int           m_rep  [W];
    logic [W-1:0] e_level, e_press, e_rel, e_long, e_rep;

    int cyc = 0;
    int cnt_press [W];
    int cnt_rel   [W];
    int cnt_long  [W];
    int cnt_rep   [W];
    int last_press [W];
    int last_long  [W];
    int last_rep   [W];
    int prev_rep   [W];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: act=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] s;
        bit           tick;
        bit           rise, fall;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
            m_phase = 0;
            for (int c = 0; c < W; c++) begin
                m_run[c] = 0; m_lvl[c] = 0; m_pressed[c] = 0;
                m_held[c] = 0; m_rep[c] = 0;
            end
            e_level = '0;
        end else begin
            tick    = (m_phase == SMAX - 1);
            m_phase = (m_phase + 1) % SMAX;
            s = m_hist[SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = tb_in;
            for (int c = 0; c < W; c++) begin
                if (tick) begin
                    rise = 0; fall = 0;
                    if (s[c] != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == PULSE) begin
                            m_lvl[c] = !m_lvl[c];
                            m_run[c] = 0;
                            rise = m_lvl[c];
                            fall = !m_lvl[c];
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                    if (rise) begin
                        e_press[c] = 1'b1;
                        m_pressed[c] = 1; m_held[c] = 0; m_rep[c] = 0;
                    end else if (fall) begin
                        e_rel[c] = 1'b1;
                        m_pressed[c] = 0;
                    end else if (m_pressed[c]) begin
                        m_held[c]++;
                        if (m_held[c] == LONG) begin
                            e_long[c] = 1'b1;
                        end else if (m_held[c] > LONG) begin
                            if (tb_en[c]) begin
                                m_rep[c]++;
                                if (m_rep[c] == REPEAT) begin
                                    e_rep[c] = 1'b1;
                                    m_rep[c] = 0;
                                end
                            end else begin
                                m_rep[c] = 0;
                            end
                        end
                    end
                end
                e_level[c] = m_lvl[c];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("level",      32'(o_level),      32'(e_level));
        check_eq("press",      32'(o_press),      32'(e_press));
        check_eq("release",    32'(o_release),    32'(e_rel));
        check_eq("long_press", 32'(o_long_press), 32'(e_long));
        check_eq("repeat",     32'(o_repeat),     32'(e_rep));
        for (int c = 0; c < W; c++) begin
            if (o_press[c])      begin cnt_press[c]++; last_press[c] = cyc; end
            if (o_release[c])    cnt_rel[c]++;
            if (o_long_press[c]) begin cnt_long[c]++;  last_long[c]  = cyc; end
            if (o_repeat[c])     begin cnt_rep[c]++; prev_rep[c] = last_rep[c]; last_rep[c] = cyc; end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic settle();
        tb_in = '0;
        tb_en = '0;
        run(60);
    endtask

    initial begin
        int k;
        int p0, r0, l0, rep0;
        for (int c = 0; c < W; c++) begin
            cnt_press[c] = 0; cnt_rel[c] = 0; cnt_long[c] = 0; cnt_rep[c] = 0;
            last_press[c] = 0; last_long[c] = 0; last_rep[c] = 0; prev_rep[c] = 0;
        end

        // Reset held with both inputs high, then measure press latency.
        rst_n = 1'b0;
        tb_in = 2'b11;
        tb_en = 2'b00;
        run(10);
        rst_n = 1'b1;
        k = 0;
        while (k < 40 && o_press !== 2'b11) begin
            step();
            k++;
        end
        check_eq("rst_press_latency", 32'(k), 32'd12);
        settle();

        // Bounce: 2 high samples, 1 low, then steady high.
        p0 = cnt_press[0]; r0 = cnt_rel[0];
        tb_in = 2'b01; run(8);
        tb_in = 2'b00; run(4);
        tb_in = 2'b01; run(24);
        check_eq("bounce_press_cnt", 32'(cnt_press[0] - p0), 32'd1);
        check_eq("bounce_rel_cnt",   32'(cnt_rel[0] - r0),   32'd0);
        settle();

        // Long press with auto-repeat, then release.
        tb_en = 2'b01;
        tb_in = 2'b01; run(80);
        check_eq("long_after_press", 32'(last_long[0] - last_press[0]), 32'(LONG * SMAX));
        check_eq("repeat_period",    32'(last_rep[0] - prev_rep[0]),    32'(REPEAT * SMAX));
        tb_in = 2'b00;
        run(20);
        rep0 = cnt_rep[0];
        run(40);
        check_eq("no_repeat_after_rel", 32'(cnt_rep[0] - rep0), 32'd0);
        settle();

        // Repeat gating: stay in LONG with repeat disabled, then enable.
        rep0 = cnt_rep[0];
        tb_in = 2'b01; run(60);
        check_eq("gated_repeat_cnt", 32'(cnt_rep[0] - rep0), 32'd0);
        tb_en = 2'b01; run(24);
        check_eq("ungated_repeat_period", 32'(last_rep[0] - prev_rep[0]), 32'(REPEAT * SMAX));
        settle();

        // Release lands on the tick the long-press would have fired.
        tb_in = 2'b01;
        k = 0;
        while (k < 60 && o_press[0] !== 1'b1) begin
            step();
            k++;
        end
        l0 = cnt_long[0]; r0 = cnt_rel[0];
        run(8);
        tb_in = 2'b00;
        run(40);
        check_eq("collide_long_cnt", 32'(cnt_long[0] - l0), 32'd0);
        check_eq("collide_rel_cnt",  32'(cnt_rel[0] - r0),  32'd1);
        settle();

        // Independence: channel 1 follows channel 0 by exactly two ticks.
        tb_in = 2'b01; run(8);
        tb_in = 2'b11; run(48);
        check_eq("indep_press_offset", 32'(last_press[1] - last_press[0]), 32'(2 * SMAX));
        check_eq("indep_long_offset",  32'(last_long[1] - last_long[0]),   32'(2 * SMAX));
        check_eq("indep_ch0_long",     32'(last_long[0] - last_press[0]),  32'(LONG * SMAX));
        settle();

        // Random soak with occasional mid-operation reset.
        for (int n = 0; n < 120; n++) begin
            tb_in = W'($urandom);
            tb_en = W'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                run(3);
                rst_n = 1'b1;
            end
            run($urandom_range(1, 60));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel input conditioner for the board's pushbuttons and switches, the successor to button_parser. Each channel is synchronised, debounced symmetrically on press and release, and fed to a per-channel event state machine that emits one-cycle press, release, long-press and auto-repeat pulses. It sits in z1top between the raw BUTTONS/SWITCHES pins and the CPU reset logic and memory-mapped I/O, all on cpu_clk.

## Interface
- WIDTH, 4: number of independent channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- SAMPLE_CNT_MAX, 25000: clk cycles per sample tick (>=1); 500 us at 50 MHz.
- PULSE_CNT_MAX, 200: consecutive disagreeing samples needed to flip the debounced level (>=1).
- LONG_CNT_MAX, 2000: ticks the level must stay high before long_press (>=1).
- REPEAT_CNT_MAX, 200: ticks between repeat pulses (>=1).
- clk  input  1  clock, the CPU clock domain.
- rst_n  input  1  synchronous, active-low reset.
- in  input  WIDTH  raw asynchronous button/switch inputs, active-high.
- repeat_en  input  WIDTH  per-channel auto-repeat enable, synchronous to clk.
- level  output  WIDTH  debounced level.
- press  output  WIDTH  one-cycle pulse when level rises.
- release  output  WIDTH  one-cycle pulse when level falls.
- long_press  output  WIDTH  one-cycle pulse after LONG_CNT_MAX ticks held.
- repeat  output  WIDTH  one-cycle pulse every REPEAT_CNT_MAX ticks after long_press while repeat_en is high.

## Operation
- Synchroniser: SYNC_STAGES-deep flop chain per channel. The last stage is the sample s[i].
- Tick counter: shared, width $clog2(SAMPLE_CNT_MAX). Counts 0..SAMPLE_CNT_MAX-1 and wraps. tick is high for the one cycle where count == SAMPLE_CNT_MAX-1. With SAMPLE_CNT_MAX=1, tick is high every cycle.
- Debounce, per channel:
  - dcnt has width $clog2(PULSE_CNT_MAX+1) and saturates, never wraps.
  - On a tick where s[i] != level[i]: dcnt increments. When the incremented value would equal PULSE_CNT_MAX, level flips and dcnt clears.
  - On a tick where s[i] == level[i]: dcnt clears.
  - dcnt holds between ticks.
- Event FSM, per channel; states IDLE, HELD, LONG:
  - IDLE: on level rise, pulse press and go to HELD with hcnt=0.
  - HELD: hcnt increments on each tick. On the tick where hcnt reaches LONG_CNT_MAX, pulse long_press, go to LONG and set rcnt=0.
  - LONG: on each tick with repeat_en[i]=1, rcnt increments. When rcnt reaches REPEAT_CNT_MAX, pulse repeat and clear rcnt. On any tick with repeat_en[i]=0, rcnt clears, so re-enabling restarts a full period.
  - HELD or LONG: on level fall, pulse release and go to IDLE. This takes priority over a long_press or repeat due on the same tick; neither fires.
- Channels are fully independent. Any combination of channels may pulse in the same cycle.

## Timing
- Reset (rst_n=0 at a clk edge): synchroniser flops, the tick counter, all dcnt/hcnt/rcnt, level, press, release, long_press and repeat clear to 0. Every FSM goes to IDLE.
- Reset mid-press: all state is discarded. An input still high after reset re-debounces from zero and produces a fresh press. No release is emitted for the interrupted press.
- All outputs are registered.
- level flips in the cycle after the qualifying tick edge. press/release assert in the same cycle level changes, for exactly one cycle.
- long_press/repeat assert in the cycle after their qualifying tick, for exactly one cycle.
- Press latency from a clean input edge: SYNC_STAGES cycles, then PULSE_CNT_MAX ticks (up to (PULSE_CNT_MAX)*SAMPLE_CNT_MAX cycles depending on tick phase), plus 1 cycle.
- Glitch rejection: a bounce shorter than PULSE_CNT_MAX consecutive samples never changes level.
- long_press fires LONG_CNT_MAX ticks after press. The first repeat fires REPEAT_CNT_MAX ticks after long_press, and subsequent repeats every REPEAT_CNT_MAX ticks.

## Test plan
Bench parameters: WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, LONG_CNT_MAX=5, REPEAT_CNT_MAX=2. A tick occurs every 4 cycles.
- Reset: hold rst_n=0 for 10 cycles with in=2'b11 -> all outputs 0 throughout. After release, level[1:0] rises after exactly 3 ticks, with one press pulse per channel.
- Bounce: in[0] high for 2 ticks, low for 1 tick, high steadily -> level[0] rises only on the 3rd consecutive high sample. Exactly one press; no release.
- Long press and repeat: in[0] held 20 ticks with repeat_en[0]=1 -> press, long_press 5 ticks later, then repeat at +2, +4, +6 ... ticks. Dropping in[0] -> release after 3 low ticks and no further repeats.
- Repeat gating: repeat_en[0]=0 during LONG -> no repeat pulses. Raising it -> first repeat exactly 2 ticks later.
- Release/long collision: in[0] released so that level falls on the same tick hcnt would reach 5 -> release pulses, long_press does not.
- Independence: in=2'b01, then in[1] pressed 2 ticks later -> press[1] and long_press[1] offset by exactly 2 ticks from channel 0. Channel 0 events are unaffected.
